// File: rtl/mult_mac_if.sv
// Operand/result bundle for the mult_mac DSP hard block.
// The master side drives operand beats; the slave side (the MAC) returns results.
interface mult_mac_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+4
);
    logic                 in_valid;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 acc_en;
    logic                 acc_clr;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] y;
    logic                 ovf;

    modport master (
        output in_valid, sign_a, sign_b, a, b, acc_en, acc_clr,
        input  out_valid, y, ovf
    );

    modport slave (
        input  in_valid, sign_a, sign_b, a, b, acc_en, acc_clr,
        output out_valid, y, ovf
    );
endinterface

// File: rtl/mult_mac.sv
// Pipelined multiply-accumulate with per-operand signedness and overflow flag.
// Define MULT_MAC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mult_mac #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+4,
    parameter int PIPE      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mult_mac_if.slave  mac
);
    localparam int MSB = ACC_WIDTH-1;

    logic             o_valid;
    logic             o_sa;
    logic             o_sb;
    logic             o_en;
    logic             o_clr;
    logic [WIDTH-1:0] o_a;
    logic [WIDTH-1:0] o_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_sa    <= 1'b0;
            o_sb    <= 1'b0;
            o_en    <= 1'b0;
            o_clr   <= 1'b0;
            o_a     <= '0;
            o_b     <= '0;
        end else begin
            o_valid <= mac.in_valid;
            if (mac.in_valid) begin
                o_sa  <= mac.sign_a;
                o_sb  <= mac.sign_b;
                o_en  <= mac.acc_en;
                o_clr <= mac.acc_clr;
                o_a   <= mac.a;
                o_b   <= mac.b;
            end
        end
    end

    // One extra bit per operand lets a single signed multiplier cover every signedness mix.
    logic signed [WIDTH:0]       ext_a;
    logic signed [WIDTH:0]       ext_b;
    logic signed [2*WIDTH+1:0]   prod_full;
    logic signed [ACC_WIDTH-1:0] prod_ext;

    assign ext_a     = {o_sa & o_a[WIDTH-1], o_a};
    assign ext_b     = {o_sb & o_b[WIDTH-1], o_b};
    assign prod_full = ext_a * ext_b;
    assign prod_ext  = ACC_WIDTH'(prod_full);

    logic                 a_in_valid;
    logic                 a_in_en;
    logic                 a_in_clr;
    logic [ACC_WIDTH-1:0] a_in_prod;

    generate
        if (PIPE == 0) begin : g_nopipe
            assign a_in_valid = o_valid;
            assign a_in_en    = o_en;
            assign a_in_clr   = o_clr;
            assign a_in_prod  = prod_ext;
        end else begin : g_pipe
            logic                 pv [PIPE];
            logic                 pe [PIPE];
            logic                 pc [PIPE];
            logic [ACC_WIDTH-1:0] pp [PIPE];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE; i++) begin
                        pv[i] <= 1'b0;
                        pe[i] <= 1'b0;
                        pc[i] <= 1'b0;
                        pp[i] <= '0;
                    end
                end else begin
                    pv[0] <= o_valid;
                    if (o_valid) begin
                        pe[0] <= o_en;
                        pc[0] <= o_clr;
                        pp[0] <= prod_ext;
                    end
                    for (int i = 1; i < PIPE; i++) begin
                        pv[i] <= pv[i-1];
                        if (pv[i-1]) begin
                            pe[i] <= pe[i-1];
                            pc[i] <= pc[i-1];
                            pp[i] <= pp[i-1];
                        end
                    end
                end
            end

            assign a_in_valid = pv[PIPE-1];
            assign a_in_en    = pe[PIPE-1];
            assign a_in_clr   = pc[PIPE-1];
            assign a_in_prod  = pp[PIPE-1];
        end
    endgenerate

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 ovf_q;
    logic                 ovf_next;
    logic                 out_valid_q;
    logic                 accumulate;
    logic                 sum_ovf;

    assign accumulate = a_in_en & ~a_in_clr;
    assign sum        = acc + a_in_prod;
    assign sum_ovf    = (acc[MSB] == a_in_prod[MSB]) && (sum[MSB] != acc[MSB]);

    // A negative running sum can only overflow downward, so its sign picks the clamp rail.
    always_comb begin
        acc_next = a_in_prod;
        ovf_next = 1'b0;
        if (accumulate) begin
            ovf_next = sum_ovf;
`ifdef MULT_MAC_SAT_EN
            if (sum_ovf)
                acc_next = acc[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            else
                acc_next = sum;
`else
            acc_next = sum;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= a_in_valid;
            if (a_in_valid) begin
                acc   <= acc_next;
                ovf_q <= ovf_next;
            end
        end
    end

    assign mac.y         = acc;
    assign mac.ovf       = ovf_q;
    assign mac.out_valid = out_valid_q;
endmodule

// File: doc/mult_mac.md
# mult_mac

Parametrised pipelined multiply-accumulate hard block for the eFPGA DSP column. It is the successor to the fixed 8x8 combinational multiplier primitive. It adds configurable operand and accumulator widths, independent per-operand signedness, a configurable number of product pipeline stages, and a valid-qualified accumulator with overflow reporting. The Yosys techmap targets it for `$mul` cells and for multiply-add chains up to WIDTH x WIDTH.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; WIDTH >= 2.
- ACC_WIDTH, 2*WIDTH+4, accumulator and result width; must be >= 2*WIDTH+2.
- PIPE, 1, number of product register stages, 0..2.

Ports:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid; no backpressure, so any cycle may carry a beat.
- sign_a  in  1  a is two's-complement when 1, unsigned when 0.
- sign_b  in  1  b is two's-complement when 1, unsigned when 0.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- acc_en  in  1  1 = accumulate into the running sum; 0 = output the product alone.
- acc_clr  in  1  with acc_en=1, restart the sum from this beat's product.
- out_valid  out  1  y and ovf are valid this cycle.
- y  out  ACC_WIDTH  product or accumulated sum, two's-complement.
- ovf  out  1  overflow on this result beat; qualified by out_valid.

## Operation
- Stage O (operand register): on in_valid, captures a, b, sign_a, sign_b, acc_en and acc_clr. A valid bit travels with every stage; bubbles (valid=0) propagate every cycle.
- Operand extension: each operand is extended to WIDTH+1 bits, sign-extended if its sign bit is 1, otherwise zero-extended. The product is a signed (WIDTH+1)x(WIDTH+1) multiply, sign-extended to ACC_WIDTH. The same path serves unsigned x unsigned, signed x signed and mixed operands.
- Stages P1..PPIPE: product registers. With PIPE=0 the product feeds the accumulator stage combinationally from stage O.
- Stage A (accumulator/output register) updates only on a valid beat:
  - acc_en=0: acc <= product (acc_clr is ignored).
  - acc_en=1, acc_clr=1: acc <= product.
  - acc_en=1, acc_clr=0: acc <= acc + product, computed in ACC_WIDTH bits.
- y always equals acc. On bubble cycles acc and y hold, and out_valid=0.
- Overflow is signed overflow of the acc + product addition: both operands have the same sign and the result sign differs. Single products never overflow.
- ovf is registered alongside acc. ovf=0 on non-accumulating beats.

## Timing
- Latency: a beat sampled with in_valid in cycle 0 produces out_valid=1 in cycle PIPE+2. The default is cycle 3.
- Throughput is one beat per cycle. Back-to-back accumulating beats chain correctly, because the accumulator feeds back within stage A.
- Reset values: out_valid=0, y=0, ovf=0, all stage valid bits 0, acc=0.
- Reset asserted mid-operation discards every in-flight beat. The first accumulating beat after reset without acc_clr adds to 0.
- Inputs other than in_valid are don't-care when in_valid=0.

## Configuration
- MULT_MAC_SAT_EN defined:
  - An accumulating beat that overflows clamps acc to the signed extreme in the direction of the overflow: 2^(ACC_WIDTH-1)-1 for positive overflow, -2^(ACC_WIDTH-1) for negative overflow.
  - ovf=1 on that beat.
  - Later beats accumulate from the clamped value.
- MULT_MAC_SAT_EN undefined:
  - acc wraps modulo 2^ACC_WIDTH.
  - ovf=1 on the wrapping beat.
  - The saturation logic is absent.

## Test plan
All scenarios use WIDTH=8, ACC_WIDTH=20, PIPE=1 unless stated.
- Unsigned corner: a=0xFF, b=0xFF, sign_a=sign_b=0, acc_en=0 -> y=0x0FE01 (65025) with out_valid in cycle 3; ovf=0.
- Signed and mixed operands:
  - a=0x80, b=0x7F, both signed -> y=0xFC080 (-16256).
  - a=0xFF with sign_a=1, b=0xFF with sign_b=0 -> y=0xFFF01 (-255).
  - Run both in back-to-back cycles; the results appear in consecutive cycles.
- Accumulate with bubbles: four beats of 10x10 unsigned, acc_en=1, acc_clr=1 on the first beat only, one idle cycle between beats 2 and 3 -> y=100, 200, 300, 400. out_valid=0 and y holds 200 during the bubble.
- Overflow: 32 beats of a=b=0x80 signed, acc_en=1, acc_clr on the first beat; each product is 16384.
  - Beat 32 without the macro -> y=0x80000, ovf=1.
  - Beat 32 with MULT_MAC_SAT_EN -> y=0x7FFFF, ovf=1.
  - Beats 1-31: ovf=0.
- Reset mid-flight: two beats in the pipe, pull rst_n low for one cycle -> out_valid=0 and y=0 immediately, no stale output afterwards. The next beat 3x4 with acc_en=1, acc_clr=0 gives y=12.
- PIPE sweep: repeat the unsigned corner case with PIPE=0 and PIPE=2 -> out_valid in cycle 2 and cycle 4 respectively, same y.
